// File: rtl/mdu_pkg.sv
// Shared definitions for the E-stage multiply/divide unit: opcodes, latencies, decode helpers.
// Optional MADD/MADDU/MSUB/MSUBU support is enabled by defining MDU_MADD_EN.
package mdu_pkg;

  typedef logic [3:0] md_op_t;

  localparam md_op_t MD_NONE  = 4'd0;
  localparam md_op_t MD_MULT  = 4'd1;
  localparam md_op_t MD_MULTU = 4'd2;
  localparam md_op_t MD_DIV   = 4'd3;
  localparam md_op_t MD_DIVU  = 4'd4;
  localparam md_op_t MD_MTHI  = 4'd5;
  localparam md_op_t MD_MTLO  = 4'd6;
  localparam md_op_t MD_MFHI  = 4'd7;
  localparam md_op_t MD_MFLO  = 4'd8;
  localparam md_op_t MD_MADD  = 4'd9;
  localparam md_op_t MD_MADDU = 4'd10;
  localparam md_op_t MD_MSUB  = 4'd11;
  localparam md_op_t MD_MSUBU = 4'd12;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } mdu_state_t;

  function automatic logic is_md_start(md_op_t op);
    logic s;
    s = op inside {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU};
`ifdef MDU_MADD_EN
    s = s | (op inside {MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU});
`endif
    return s;
  endfunction

  function automatic logic is_md_div(md_op_t op);
    return op inside {MD_DIV, MD_DIVU};
  endfunction

  function automatic logic is_md_any(md_op_t op);
    return is_md_start(op) | (op inside {MD_MTHI, MD_MTLO, MD_MFHI, MD_MFLO});
  endfunction

endpackage

// File: rtl/mdu_if.sv
// Pipeline-side bundle of the multiply/divide unit: E-stage request in, stall/HI/LO out.
interface mdu_if;
  import mdu_pkg::*;

  md_op_t      md_op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        req;
  logic        md_use_d;
  logic        busy;
  logic        md_stall;
  logic [31:0] md_out;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output md_op, src_a, src_b, req, md_use_d,
    input  busy, md_stall, md_out, hi, lo
  );

  modport slave (
    input  md_op, src_a, src_b, req, md_use_d,
    output busy, md_stall, md_out, hi, lo
  );

endinterface

// File: rtl/mdu_arith.sv
// Combinational datapath: 64-bit {hi,lo} result for the E-stage MD op (MDU_MADD_EN adds accumulate ops).
module mdu_arith
  import mdu_pkg::*;
(
  input  md_op_t      md_op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  output logic [63:0] res,
  output logic        wr_en
);

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic        b_zero;
  logic        div_ovf;
  logic [31:0] den_s;
  logic [31:0] den_u;
  logic [31:0] quo_s;
  logic [31:0] rem_s;
  logic [31:0] quo_u;
  logic [31:0] rem_u;

  assign prod_s = $signed({{32{src_a[31]}}, src_a}) * $signed({{32{src_b[31]}}, src_b});
  assign prod_u = {32'b0, src_a} * {32'b0, src_b};

  // Dividing by 1 in the zero and overflow cases keeps the divider defined and
  // yields exactly the MIN/-1 result (quotient = dividend, remainder = 0).
  assign b_zero  = (src_b == 32'd0);
  assign div_ovf = (src_a == 32'h8000_0000) && (src_b == 32'hFFFF_FFFF);
  assign den_s   = (b_zero || div_ovf) ? 32'd1 : src_b;
  assign den_u   = b_zero ? 32'd1 : src_b;

  assign quo_s = $signed(src_a) / $signed(den_s);
  assign rem_s = $signed(src_a) % $signed(den_s);
  assign quo_u = src_a / den_u;
  assign rem_u = src_a % den_u;

`ifdef MDU_MADD_EN
  logic [63:0] acc;
  assign acc = {hi, lo};
`else
  logic unused_hilo;
  assign unused_hilo = ^{hi, lo};
`endif

  always_comb begin
    res   = 64'd0;
    wr_en = 1'b1;
    case (md_op)
      MD_MULT:  res = prod_s;
      MD_MULTU: res = prod_u;
      MD_DIV: begin
        res   = {rem_s, quo_s};
        wr_en = ~b_zero;
      end
      MD_DIVU: begin
        res   = {rem_u, quo_u};
        wr_en = ~b_zero;
      end
`ifdef MDU_MADD_EN
      MD_MADD:  res = acc + prod_s;
      MD_MADDU: res = acc + prod_u;
      MD_MSUB:  res = acc - prod_s;
      MD_MSUBU: res = acc - prod_u;
`endif
      default:  res = 64'd0;
    endcase
  end

endmodule

// File: rtl/mdu_unit.sv
// E-stage multiply/divide unit: owns HI/LO, models mult/div latency, drives the D-stage stall.
// Build option MDU_MADD_EN enables the MADD/MADDU/MSUB/MSUBU accumulate ops.
//
// state   | meaning
// ST_IDLE | no operation in flight; start, MTHI/MTLO accepted
// ST_BUSY | counting down; pending result commits to HI/LO when count goes 1->0
module mdu_unit
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  mdu_if.slave bus
);

  localparam int CNT_W = 16;

  mdu_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;
  logic [63:0]      pend_q, pend_d;
  logic             pend_wr_q, pend_wr_d;
  logic [63:0]      arith_res;
  logic             arith_wr;
  logic             busy;
  logic             start;

  mdu_arith u_arith (
    .md_op (bus.md_op),
    .src_a (bus.src_a),
    .src_b (bus.src_b),
    .hi    (hi_q),
    .lo    (lo_q),
    .res   (arith_res),
    .wr_en (arith_wr)
  );

  assign busy  = (state_q == ST_BUSY);
  assign start = is_md_start(bus.md_op) & ~bus.req & ~busy;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_d    = pend_q;
    pend_wr_d = pend_wr_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          pend_d    = arith_res;
          pend_wr_d = arith_wr;
          cnt_d     = is_md_div(bus.md_op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
          state_d   = ST_BUSY;
        end else if (!bus.req) begin
          if (bus.md_op == MD_MTHI) hi_d = bus.src_a;
          if (bus.md_op == MD_MTLO) lo_d = bus.src_a;
        end
      end
      ST_BUSY: begin
        // A flush (req) here belongs to a younger instruction; the op in flight still commits.
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_IDLE;
          if (pend_wr_q) {hi_d, lo_d} = pend_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_q    <= '0;
      pend_wr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_q    <= pend_d;
      pend_wr_q <= pend_wr_d;
    end
  end

  always_comb begin
    case (bus.md_op)
      MD_MFHI: bus.md_out = hi_q;
      MD_MFLO: bus.md_out = lo_q;
      default: bus.md_out = 32'd0;
    endcase
  end

  assign bus.busy     = busy;
  assign bus.md_stall = bus.md_use_d & (busy | start);
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;

endmodule

// File: tb/tb_mdu_unit.sv
// Directed plus random bench for mdu_unit against a plain-arithmetic HI/LO reference model.
module tb_mdu_unit;
  import mdu_pkg::*;

  localparam int MULT_C = 5;
  localparam int DIV_C  = 10;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;

  mdu_if bus ();

  mdu_unit dut (
    .clk   (clk),
    .reset (reset_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_hi   = 32'd0;
  logic [31:0] exp_lo   = 32'd0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Reference: applies the op's architectural effect to h/l, returns busy latency (0 = no start).
  function automatic int ref_op(input md_op_t op, input logic [31:0] a, input logic [31:0] b,
                                inout logic [31:0] h, inout logic [31:0] l);
    longint          sa, sb;
    longint unsigned ua, ub;
    logic [63:0]     p;
    int              qa, qb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = 64'(a);
    ub = 64'(b);
    ref_op = 0;
    case (op)
      MD_MULT:  begin p = sa * sb; {h, l} = p; ref_op = MULT_C; end
      MD_MULTU: begin p = ua * ub; {h, l} = p; ref_op = MULT_C; end
      MD_DIV: begin
        ref_op = DIV_C;
        if (b != 32'd0) begin
          if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            l = a;
            h = 32'd0;
          end else begin
            qa = a;
            qb = b;
            l = qa / qb;
            h = qa % qb;
          end
        end
      end
      MD_DIVU: begin
        ref_op = DIV_C;
        if (b != 32'd0) begin
          l = a / b;
          h = a % b;
        end
      end
`ifdef MDU_MADD_EN
      MD_MADD:  begin p = {h, l} + 64'(sa * sb); {h, l} = p; ref_op = MULT_C; end
      MD_MADDU: begin p = {h, l} + 64'(ua * ub); {h, l} = p; ref_op = MULT_C; end
      MD_MSUB:  begin p = {h, l} - 64'(sa * sb); {h, l} = p; ref_op = MULT_C; end
      MD_MSUBU: begin p = {h, l} - 64'(ua * ub); {h, l} = p; ref_op = MULT_C; end
`endif
      default: ref_op = 0;
    endcase
  endfunction

  task automatic run_md(input string tag, input md_op_t op, input logic [31:0] a,
                        input logic [31:0] b, input int req_at);
    logic [31:0] eh, el;
    int          lat, busy_n, stall_n;
    logic        held;
    eh = exp_hi;
    el = exp_lo;
    lat = ref_op(op, a, b, eh, el);
    busy_n = 0;
    stall_n = 0;
    held = 1'b1;
    bus.md_op = op;
    bus.src_a = a;
    bus.src_b = b;
    bus.req = 1'b0;
    bus.md_use_d = 1'b1;
    #1;
    if (bus.md_stall) stall_n++;
    @(posedge clk); #1;
    bus.md_op = MD_NONE;
    bus.src_a = $urandom;
    bus.src_b = $urandom;
    for (int i = 0; i < DIV_C + 5 && bus.busy; i++) begin
      busy_n++;
      bus.req = (i == req_at);
      #1;
      if (bus.md_stall) stall_n++;
      if (bus.hi !== exp_hi || bus.lo !== exp_lo) held = 1'b0;
      @(posedge clk); #1;
    end
    bus.req = 1'b0;
    bus.md_use_d = 1'b0;
    check({tag, "_busy_cycles"}, 32'(busy_n), 32'(lat));
    check({tag, "_stall_cycles"}, 32'(stall_n), 32'(lat + ((lat > 0) ? 1 : 0)));
    check({tag, "_hold"}, {31'b0, held}, 32'd1);
    check({tag, "_busy_end"}, {31'b0, bus.busy}, 32'd0);
    check({tag, "_hi"}, bus.hi, eh);
    check({tag, "_lo"}, bus.lo, el);
    exp_hi = eh;
    exp_lo = el;
  endtask

  task automatic mt(input md_op_t op, input logic [31:0] v, input logic rq);
    bus.md_op = op;
    bus.src_a = v;
    bus.req = rq;
    bus.md_use_d = 1'b0;
    @(posedge clk); #1;
    if (!rq) begin
      if (op == MD_MTHI) exp_hi = v;
      else exp_lo = v;
    end
    bus.md_op = MD_NONE;
    bus.req = 1'b0;
  endtask

  initial begin
    md_op_t      ops[$];
    md_op_t      op;
    logic [31:0] a, b, old_hi;
    logic        quiet;
    int          dummy;

    bus.md_op = MD_NONE;
    bus.src_a = 32'd0;
    bus.src_b = 32'd0;
    bus.req = 1'b0;
    bus.md_use_d = 1'b0;

    #2;
    check("rst_hi", bus.hi, 32'd0);
    check("rst_lo", bus.lo, 32'd0);
    check("rst_busy", {31'b0, bus.busy}, 32'd0);
    check("rst_stall", {31'b0, bus.md_stall}, 32'd0);
    bus.md_op = MD_MFHI;
    #1;
    check("rst_md_out", bus.md_out, 32'd0);
    bus.md_op = MD_NONE;
    #10;
    reset_n = 1'b1;
    @(posedge clk); #1;

    run_md("mult", MD_MULT, 32'hFFFF_FFFE, 32'h0000_0003, -1);
    check("mult_hi_const", bus.hi, 32'hFFFF_FFFF);
    check("mult_lo_const", bus.lo, 32'hFFFF_FFFA);
    run_md("multu", MD_MULTU, 32'hFFFF_FFFE, 32'h0000_0003, -1);
    check("multu_hi_const", bus.hi, 32'h0000_0002);
    check("multu_lo_const", bus.lo, 32'hFFFF_FFFA);
    run_md("div", MD_DIV, 32'hFFFF_FFF9, 32'd2, -1);
    check("div_lo_const", bus.lo, 32'hFFFF_FFFD);
    check("div_hi_const", bus.hi, 32'hFFFF_FFFF);

    mt(MD_MTHI, 32'h11, 1'b0);
    mt(MD_MTLO, 32'h22, 1'b0);
    run_md("divu_zero", MD_DIVU, 32'd7, 32'd0, -1);
    check("divu_zero_hi_const", bus.hi, 32'h11);
    check("divu_zero_lo_const", bus.lo, 32'h22);

    run_md("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, -1);
    check("div_ovf_lo_const", bus.lo, 32'h8000_0000);
    check("div_ovf_hi_const", bus.hi, 32'h0);

    // MULT flushed in its start cycle
    bus.md_op = MD_MULT;
    bus.src_a = 32'd5;
    bus.src_b = 32'd7;
    bus.req = 1'b1;
    bus.md_use_d = 1'b1;
    #1;
    check("mult_req_stall", {31'b0, bus.md_stall}, 32'd0);
    @(posedge clk); #1;
    bus.md_op = MD_NONE;
    bus.req = 1'b0;
    bus.md_use_d = 1'b0;
    check("mult_req_busy", {31'b0, bus.busy}, 32'd0);
    check("mult_req_hi", bus.hi, exp_hi);
    check("mult_req_lo", bus.lo, exp_lo);

    mt(MD_MTHI, 32'h1234, 1'b1);
    check("mthi_req_hi", bus.hi, exp_hi);

    run_md("div_req", MD_DIV, 32'd100, 32'd7, 2);
    check("div_req_lo_const", bus.lo, 32'd14);
    check("div_req_hi_const", bus.hi, 32'd2);

    mt(MD_MTLO, 32'hCAFE, 1'b0);
    bus.md_op = MD_MFLO;
    #1;
    check("mflo", bus.md_out, 32'h0000_CAFE);
    bus.md_op = MD_MFHI;
    #1;
    check("mfhi", bus.md_out, exp_hi);
    bus.md_op = MD_NONE;
    #1;
    check("md_out_none", bus.md_out, 32'd0);

    // MFHI while a MULT is in flight reads the committed HI, not the pending one
    old_hi = exp_hi;
    bus.md_op = MD_MULT;
    bus.src_a = 32'h0001_0000;
    bus.src_b = 32'h0001_0000;
    @(posedge clk); #1;
    dummy = ref_op(MD_MULT, 32'h0001_0000, 32'h0001_0000, exp_hi, exp_lo);
    bus.md_op = MD_MFHI;
    #1;
    check("mfhi_busy_flag", {31'b0, bus.busy}, 32'd1);
    check("mfhi_busy_out", bus.md_out, old_hi);
    bus.md_op = MD_NONE;
    for (int i = 0; i < 20 && bus.busy; i++) begin
      @(posedge clk); #1;
    end
    check("mfhi_busy_done", {31'b0, bus.busy}, 32'd0);
    check("mfhi_busy_hi", bus.hi, 32'd1);
    check("mfhi_busy_lo", bus.lo, 32'd0);

    // asynchronous reset in the middle of a MULT
    bus.md_op = MD_MULT;
    bus.src_a = 32'd3;
    bus.src_b = 32'd5;
    @(posedge clk); #1;
    bus.md_op = MD_NONE;
    @(posedge clk); #3;
    reset_n = 1'b0;
    #1;
    check("arst_busy", {31'b0, bus.busy}, 32'd0);
    check("arst_hi", bus.hi, 32'd0);
    check("arst_lo", bus.lo, 32'd0);
    exp_hi = 32'd0;
    exp_lo = 32'd0;
    #3;
    reset_n = 1'b1;
    quiet = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (bus.busy || bus.hi !== 32'd0 || bus.lo !== 32'd0) quiet = 1'b0;
    end
    check("arst_no_commit", {31'b0, quiet}, 32'd1);

    mt(MD_MTHI, 32'h0, 1'b0);
    mt(MD_MTLO, 32'hFFFF_FFFF, 1'b0);
    run_md("maddu", MD_MADDU, 32'd1, 32'd1, -1);
`ifdef MDU_MADD_EN
    check("maddu_hi_const", bus.hi, 32'd1);
    check("maddu_lo_const", bus.lo, 32'd0);
`else
    check("maddu_off_hi_const", bus.hi, 32'd0);
    check("maddu_off_lo_const", bus.lo, 32'hFFFF_FFFF);
`endif

    ops = '{MD_MULT, MD_MULTU, MD_DIV, MD_DIVU};
`ifdef MDU_MADD_EN
    ops.push_back(MD_MADD);
    ops.push_back(MD_MADDU);
    ops.push_back(MD_MSUB);
    ops.push_back(MD_MSUBU);
`endif
    for (int k = 0; k < 30; k++) begin
      op = ops[$urandom_range(0, ops.size() - 1)];
      a = $urandom;
      case ($urandom_range(0, 3))
        0:       b = $urandom_range(0, 3);
        1:       b = 32'hFFFF_FFFF;
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 4) == 0) a = 32'h8000_0000;
      if ($urandom_range(0, 3) == 0) begin
        mt(MD_MTHI, $urandom, 1'b0);
        mt(MD_MTLO, $urandom, 1'b0);
      end
      run_md("rand", op, a, b, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
